interval_timer_ctrl: RTL and testbench
======================================

# interval_timer_ctrl

Sequencing controller for the team's free-running WIDTH-bit up-counter, turning it into a programmable interval timer. It accepts a period and mode over a valid/ready config port, starts and stops counting on command pulses, and emits a one-cycle `tick` at terminal count. It operates in one-shot mode (stop in DONE) or periodic mode (auto-reload). It sits between a register/command front end and any logic that needs timed events.

## Interface
- `WIDTH`, 4: counter and period width in bits.
- `clk`  in  1: single clock, all state updates on its rising edge.
- `rst`  in  1: synchronous, active-high reset.
- `cfg_valid`  in  1: config request.
- `cfg_ready`  out  1: config can be accepted.
- `cfg_period`  in  WIDTH: terminal count P; the interval is P+1 cycles.
- `cfg_periodic`  in  1: 1 = auto-reload, 0 = one-shot.
- `start`  in  1: start command, sampled each cycle.
- `stop`  in  1: stop command, sampled each cycle.
- `count`  out  WIDTH: current counter value.
- `busy`  out  1: high in RUN.
- `tick`  out  1: one-cycle pulse after terminal count.
- `done`  out  1: high in DONE (one-shot finished).

## Operation
- States: IDLE, RUN, DONE.
- Reset values:
  - state IDLE, `count`=0, period register = all ones, periodic register = 0.
  - `tick`=0, `done`=0, `busy`=0, `cfg_ready`=1.
- `cfg_ready`=1 in IDLE and DONE, 0 in RUN.
- Config acceptance:
  - Config is accepted when `cfg_valid && cfg_ready`; it latches period and mode.
  - Accept in DONE: go to IDLE, `count`←0.
- IDLE:
  - `start` (and no `stop`): go to RUN, `count`←0.
  - `stop` is ignored.
- RUN, counting: `count` increments by 1 each cycle while `count` != P.
- RUN, `count`==P:
  - `tick`←1 for one cycle on the next edge.
  - Periodic: `count`←0 and stay in RUN.
  - One-shot: go to DONE, `count` holds P.
- RUN, `stop`: go to IDLE with `count` frozen; `tick` is suppressed.
- RUN, `start` alone: ignored (no restart).
- DONE:
  - `start`: go to RUN, `count`←0.
  - `stop`: go to IDLE, `count`←0.
- Counter width rules:
  - `count` never exceeds P, so no WIDTH overflow occurs.
  - P=0 in periodic mode gives `tick` every cycle and `count` stuck at 0.
- Simultaneous events:
  - `start` and `stop` together: `stop` wins.
  - `stop` at terminal count: `stop` wins, no `tick`.
  - Config plus `start` in the same IDLE/DONE cycle: the new config is accepted, and the run uses the new period and mode.
- `rst` mid-run returns everything to reset values on the next edge, overriding all inputs. No `tick` is emitted.

## Timing
- All outputs are registered; there is no combinational path from inputs to outputs.
- `start` sampled at edge k:
  - After edge k: `busy`=1, `count`=0.
  - After edge k+n: `count`=n, for n ≤ P.
  - After edge k+P+1: `tick`=1 for one cycle, and `count`=0 (periodic) or P with `done`=1 (one-shot).
- Periodic tick spacing: exactly P+1 cycles.
- `stop` at edge j: `busy`=0 after edge j.
- Config handshake completes in the same cycle it is accepted.

## Structure
- Package `timer_pkg` holds:
  - the state enum (IDLE, RUN, DONE);
  - the default WIDTH constant.
- Sub-module `interval_counter`: WIDTH-bit up-counter with synchronous `clr` and `en` inputs and a `count` output. The FSM drives `clr`/`en` and compares `count` against the period register.

## Test plan
- Reset: `rst`=1 for 2 cycles → `count`=0, `busy`=`done`=`tick`=0, `cfg_ready`=1. `rst`=0 with no `start` → `count` stays 0.
- One-shot, P=5:
  - Config, then `start` → `count` 0,1,…,5 on consecutive cycles.
  - Then `tick`=1 for one cycle, `done`=1, `count` holds 5.
  - Further edges → no change.
- Periodic, P=15:
  - `start`, 40 cycles → `tick` every 16 cycles.
  - `count` wraps 15→0 on each tick edge; `busy` stays 1.
- Stop/restart, P=9 periodic:
  - `stop` when `count`=4 → IDLE, `count` frozen at 4, no `tick`.
  - `start` → `count`=0, then 1, …
- Collisions:
  - `start` and `stop` together in IDLE → stays IDLE.
  - `stop` at `count`==P → no `tick`.
  - Config P=2 plus `start` in the same cycle → first `tick` arrives 3 cycles after the start edge.
- Mid-run reset, `count`=7 → after the `rst` edge, `count`=0 and IDLE. `cfg_valid` while RUN → `cfg_ready`=0, and the period is unchanged.

Source files
------------

// File: rtl/timer_pkg.sv
// Shared types and constants for the interval timer controller.
package timer_pkg;

  // Default counter and period width in bits.
  localparam int DEFAULT_WIDTH = 4;

  // Controller sequencing states.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage : timer_pkg

// File: rtl/interval_timer_ctrl_if.sv
// Config handshake, command and status bundle of the interval timer.
// master = register/command front end, slave = timer controller.
interface interval_timer_ctrl_if
  import timer_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
);

  logic             cfg_valid;
  logic             cfg_ready;
  logic [WIDTH-1:0] cfg_period;
  logic             cfg_periodic;
  logic             start;
  logic             stop;
  logic [WIDTH-1:0] count;
  logic             busy;
  logic             tick;
  logic             done;

  modport master (
    output cfg_valid, cfg_period, cfg_periodic, start, stop,
    input  cfg_ready, count, busy, tick, done
  );

  modport slave (
    input  cfg_valid, cfg_period, cfg_periodic, start, stop,
    output cfg_ready, count, busy, tick, done
  );

endinterface : interval_timer_ctrl_if

// File: rtl/interval_counter.sv
// WIDTH-bit up-counter with synchronous clear and count enable.
// Clear has priority over enable; with neither asserted the value holds.
module interval_counter #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_clr,
  input  logic             i_en,
  output logic [WIDTH-1:0] o_count
);

  localparam logic [WIDTH-1:0] ONE = 1;

  logic [WIDTH-1:0] r_count;

  // Counter register: reset, clear, increment or hold.
  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments on registered state, so every flop
    // samples values from before the edge regardless of block ordering.
    if (rst) begin
      r_count <= '0;
    end else if (i_clr) begin
      r_count <= '0;
    end else if (i_en) begin
      r_count <= r_count + ONE;
    end
  end

  assign o_count = r_count;

endmodule : interval_counter

// File: rtl/interval_timer_ctrl.sv
// Interval timer controller: sequences the up-counter through IDLE/RUN/DONE,
// latches period and mode from the config port, and emits a registered
// one-cycle tick when the count leaves its terminal value P.
module interval_timer_ctrl
  import timer_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic                 clk,
  input  logic                 rst,
  interval_timer_ctrl_if.slave bus
);

  state_t           r_state;
  state_t           w_state_nxt;
  logic [WIDTH-1:0] r_period;
  logic             r_periodic;
  logic             r_tick;

  logic             w_cfg_accept;
  logic             w_terminal;
  logic             w_cnt_clr;
  logic             w_cnt_en;
  logic             w_tick_nxt;
  logic [WIDTH-1:0] w_count;

  // Config is only offered outside RUN, so the period cannot change mid-run.
  assign w_cfg_accept = bus.cfg_valid && (r_state != RUN);
  assign w_terminal   = (w_count == r_period);

  interval_counter #(
    .WIDTH (WIDTH)
  ) u_counter (
    .clk     (clk),
    .rst     (rst),
    .i_clr   (w_cnt_clr),
    .i_en    (w_cnt_en),
    .o_count (w_count)
  );

  // Latch period and mode on an accepted config beat.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_period   <= '1;
      r_periodic <= 1'b0;
    end else if (w_cfg_accept) begin
      r_period   <= bus.cfg_period;
      r_periodic <= bus.cfg_periodic;
    end
  end

  // State and tick registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_tick  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_tick  <= w_tick_nxt;
    end
  end

  // Next-state and counter control; stop always beats start and terminal count.
  always_comb begin
    // NOTE: every signal gets a default before the case so no path leaves
    // one unassigned, which would otherwise infer a latch.
    w_state_nxt = r_state;
    w_cnt_clr   = 1'b0;
    w_cnt_en    = 1'b0;
    w_tick_nxt  = 1'b0;
    case (r_state)
      IDLE: begin
        if (bus.start && !bus.stop) begin
          w_state_nxt = RUN;
          w_cnt_clr   = 1'b1;
        end
      end
      RUN: begin
        if (bus.stop) begin
          w_state_nxt = IDLE;
        end else if (w_terminal) begin
          w_tick_nxt = 1'b1;
          if (r_periodic) begin
            w_cnt_clr = 1'b1;
          end else begin
            w_state_nxt = DONE;
          end
        end else begin
          w_cnt_en = 1'b1;
        end
      end
      DONE: begin
        if (bus.stop) begin
          w_state_nxt = IDLE;
          w_cnt_clr   = 1'b1;
        end else if (bus.start) begin
          w_state_nxt = RUN;
          w_cnt_clr   = 1'b1;
        end else if (w_cfg_accept) begin
          w_state_nxt = IDLE;
          w_cnt_clr   = 1'b1;
        end
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

  // Status outputs decode registered state only.
  assign bus.cfg_ready = (r_state != RUN);
  assign bus.busy      = (r_state == RUN);
  assign bus.done      = (r_state == DONE);
  assign bus.tick      = r_tick;
  assign bus.count     = w_count;

endmodule : interval_timer_ctrl

// File: tb/tb_interval_timer_ctrl.sv
// Self-checking bench for interval_timer_ctrl: an elapsed-time model is
// compared against the DUT on every falling edge, and directed scenarios
// pin hand-computed values.
module tb_interval_timer_ctrl;

  localparam int W = 4;

  logic clk;
  logic rst;

  interval_timer_ctrl_if #(.WIDTH(W)) bus ();

  interval_timer_ctrl #(.WIDTH(W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Inputs captured at each rising edge (stimulus only changes on falling edges).
  logic s_seen = 1'b0;
  logic s_rst, s_valid, s_periodic, s_start, s_stop;
  int   s_period;

  initial forever begin
    @(posedge clk);
    s_rst      = rst;
    s_valid    = bus.cfg_valid;
    s_period   = int'(bus.cfg_period);
    s_periodic = bus.cfg_periodic;
    s_start    = bus.start;
    s_stop     = bus.stop;
    s_seen     = 1'b1;
  end

  // Model: a run is described by cycles elapsed since the start edge.
  int m_mode;      // 0 idle, 1 running, 2 finished one-shot
  int m_elapsed;
  int m_held;      // count shown when not running
  int m_period;
  bit m_periodic;
  bit m_tick;

  function automatic int model_count();
    if (m_mode == 1)
      return m_periodic ? (m_elapsed % (m_period + 1)) : m_elapsed;
    return m_held;
  endfunction

  task automatic model_step();
    bit accept;
    if (s_rst) begin
      m_mode = 0; m_held = 0; m_period = (1 << W) - 1; m_periodic = 0; m_tick = 0;
      return;
    end
    m_tick = 0;
    accept = s_valid && (m_mode != 1);
    if (accept) begin
      m_period   = s_period;
      m_periodic = s_periodic;
    end
    case (m_mode)
      0: if (s_start && !s_stop) begin m_mode = 1; m_elapsed = 0; end
      1: begin
        if (s_stop) begin
          m_held = model_count();
          m_mode = 0;
        end else begin
          m_elapsed++;
          if (m_elapsed % (m_period + 1) == 0) m_tick = 1;
          if (!m_periodic && m_elapsed == m_period + 1) begin
            m_mode = 2;
            m_held = m_period;
          end
        end
      end
      default: begin
        if (s_stop) begin m_mode = 0; m_held = 0; end
        else if (s_start) begin m_mode = 1; m_elapsed = 0; end
        else if (accept) begin m_mode = 0; m_held = 0; end
      end
    endcase
  endtask

  // Compare process: outputs are settled by the falling edge.
  initial forever begin
    @(negedge clk);
    if (s_seen) begin
      model_step();
      check("count",     32'(bus.count),     32'(model_count()));
      check("busy",      32'(bus.busy),      32'(m_mode == 1));
      check("done",      32'(bus.done),      32'(m_mode == 2));
      check("tick",      32'(bus.tick),      32'(m_tick));
      check("cfg_ready", 32'(bus.cfg_ready), 32'(m_mode != 1));
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic cfg(input int period, input bit periodic);
    bus.cfg_valid    = 1'b1;
    bus.cfg_period   = W'(period);
    bus.cfg_periodic = periodic;
  endtask

  int ntick;
  int first_tick;

  initial begin
    rst = 1'b1;
    bus.cfg_valid = 1'b0; bus.cfg_period = '0; bus.cfg_periodic = 1'b0;
    bus.start = 1'b0; bus.stop = 1'b0;

    // Reset
    cyc(2);
    check("rst_count", 32'(bus.count), 0);
    check("rst_busy",  32'(bus.busy), 0);
    check("rst_done",  32'(bus.done), 0);
    check("rst_tick",  32'(bus.tick), 0);
    check("rst_ready", 32'(bus.cfg_ready), 1);
    rst = 1'b0;
    cyc(3);
    check("idle_count", 32'(bus.count), 0);

    // One-shot, P=5
    cfg(5, 1'b0);
    cyc(1);
    bus.cfg_valid = 1'b0; bus.start = 1'b1;
    cyc(1);
    bus.start = 1'b0;
    check("os_busy", 32'(bus.busy), 1);
    check("os_c0", 32'(bus.count), 0);
    for (int n = 1; n <= 5; n++) begin
      cyc(1);
      check("os_cn", 32'(bus.count), 32'(n));
    end
    cyc(1);
    check("os_tick", 32'(bus.tick), 1);
    check("os_done", 32'(bus.done), 1);
    check("os_hold", 32'(bus.count), 5);
    cyc(1);
    check("os_tick_off", 32'(bus.tick), 0);
    cyc(3);
    check("os_still", 32'(bus.count), 5);
    check("os_still_done", 32'(bus.done), 1);

    // Periodic, P=15 (config in DONE returns to IDLE with count cleared)
    cfg(15, 1'b1);
    cyc(1);
    bus.cfg_valid = 1'b0;
    check("cfg_in_done_idle", 32'(bus.done), 0);
    check("cfg_in_done_cnt",  32'(bus.count), 0);
    bus.start = 1'b1;
    cyc(1);
    bus.start = 1'b0;
    ntick = 0; first_tick = 0;
    for (int i = 1; i <= 40; i++) begin
      cyc(1);
      if (bus.tick) begin
        if (ntick == 0) first_tick = i;
        ntick++;
      end
      if (i == 15) check("per_c15", 32'(bus.count), 15);
      if (i == 16) check("per_wrap", 32'(bus.count), 0);
      if (i == 32) check("per_tick2", 32'(bus.tick), 1);
    end
    check("per_ntick", 32'(ntick), 2);
    check("per_first", 32'(first_tick), 16);
    check("per_busy", 32'(bus.busy), 1);

    // Stop/restart, P=9 periodic
    bus.stop = 1'b1;
    cyc(1);
    bus.stop = 1'b0;
    cfg(9, 1'b1);
    cyc(1);
    bus.cfg_valid = 1'b0; bus.start = 1'b1;
    cyc(1);
    bus.start = 1'b0;
    cyc(4);
    check("ss_c4", 32'(bus.count), 4);
    bus.stop = 1'b1;
    cyc(1);
    bus.stop = 1'b0;
    check("ss_busy", 32'(bus.busy), 0);
    check("ss_frozen", 32'(bus.count), 4);
    check("ss_notick", 32'(bus.tick), 0);
    cyc(3);
    check("ss_frozen2", 32'(bus.count), 4);
    bus.start = 1'b1;
    cyc(1);
    bus.start = 1'b0;
    check("rs_c0", 32'(bus.count), 0);
    cyc(1);
    check("rs_c1", 32'(bus.count), 1);

    // Collisions: start+stop in IDLE, stop at terminal count
    bus.stop = 1'b1;
    cyc(1);
    bus.start = 1'b1;
    cyc(1);
    bus.start = 1'b0; bus.stop = 1'b0;
    check("ss_both_idle", 32'(bus.busy), 0);
    bus.start = 1'b1;
    cyc(1);
    bus.start = 1'b0;
    cyc(9);
    check("term_c9", 32'(bus.count), 9);
    bus.stop = 1'b1;
    cyc(1);
    bus.stop = 1'b0;
    check("term_stop_tick", 32'(bus.tick), 0);
    check("term_stop_busy", 32'(bus.busy), 0);
    check("term_stop_cnt", 32'(bus.count), 9);

    // Config P=2 plus start in the same cycle
    cfg(2, 1'b1);
    bus.start = 1'b1;
    cyc(1);
    bus.cfg_valid = 1'b0; bus.start = 1'b0;
    check("cs_c0", 32'(bus.count), 0);
    cyc(2);
    check("cs_notick", 32'(bus.tick), 0);
    cyc(1);
    check("cs_tick3", 32'(bus.tick), 1);

    // Mid-run reset at count 7
    bus.stop = 1'b1;
    cyc(1);
    bus.stop = 1'b0;
    cfg(12, 1'b0);
    cyc(1);
    bus.cfg_valid = 1'b0; bus.start = 1'b1;
    cyc(1);
    bus.start = 1'b0;
    cyc(7);
    check("mr_c7", 32'(bus.count), 7);
    rst = 1'b1;
    cyc(1);
    rst = 1'b0;
    check("mr_count", 32'(bus.count), 0);
    check("mr_busy", 32'(bus.busy), 0);
    check("mr_tick", 32'(bus.tick), 0);

    // Config attempt during RUN is refused; reset period (15) stays in force
    bus.start = 1'b1;
    cyc(1);
    bus.start = 1'b0;
    cfg(3, 1'b1);
    cyc(3);
    check("run_ready", 32'(bus.cfg_ready), 0);
    bus.cfg_valid = 1'b0;
    cyc(12);
    check("run_c15", 32'(bus.count), 15);
    check("run_notdone", 32'(bus.done), 0);
    cyc(1);
    check("run_done", 32'(bus.done), 1);
    check("run_tick", 32'(bus.tick), 1);
    check("run_hold", 32'(bus.count), 15);

    cyc(2);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule : tb_interval_timer_ctrl
